mem_line_bridge: RTL and testbench

Memory-side bridge between the multicycle RV32I control/datapath word port and a 64-bit burst physical memory. It accepts word reads and byte-masked word writes, and satisfies them from a single 256-bit line buffer. Misses are filled with a 4-beat burst, and writes are read-modify-written back as a full-line 4-beat burst (write-through). It sits directly downstream of the control FSM and returns `mem_resp` to it.

---
 rtl/mem_line_bridge_pkg.sv | 32 +++
 rtl/mem_line_bridge_if.sv | 37 +++
 rtl/mem_line_bridge_line_buffer.sv | 39 +++
 rtl/mem_line_bridge.sv | 194 +++++++++++++++++++
 tb/tb_mem_line_bridge.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_bridge_pkg.sv
// Shared types for the memory line bridge: FSM states, line geometry and the byte-merge helper.
package cache_types;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned BEAT_BITS   = 64;
    localparam int unsigned WORD_BITS   = 32;

    typedef logic [31-OFFSET_BITS:0] line_tag_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        MERGE,
        FLUSH,
        RESP
    } bridge_state_t;

    function automatic logic [WORD_BITS-1:0] merge_bytes(
        input logic [WORD_BITS-1:0] old_word,
        input logic [WORD_BITS-1:0] new_word,
        input logic [3:0]           be
    );
        logic [WORD_BITS-1:0] w;
        w = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_line_bridge_if.sv
// Word-port (CPU side) and burst-port (physical memory side) bundles for mem_line_bridge.
interface cpu_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );
    modport slave (
        input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

interface pmem_if;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_rdata;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_line_bridge_line_buffer.sv
// Line storage for mem_line_bridge: beat-wide fill port, byte-masked word merge port, word and beat read ports.
module line_buffer
    import cache_types::*;
#(
    parameter int unsigned BEATS = 4,
    localparam int unsigned CNT_W  = $clog2(BEATS),
    localparam int unsigned WORD_W = $clog2(BEATS * 2)
) (
    input  logic                 clk,
    input  logic                 fill_en,
    input  logic [CNT_W-1:0]     fill_beat,
    input  logic [BEAT_BITS-1:0] fill_data,
    input  logic                 merge_en,
    input  logic [WORD_W-1:0]    merge_word,
    input  logic [WORD_BITS-1:0] merge_data,
    input  logic [3:0]           merge_be,
    input  logic [WORD_W-1:0]    rd_word,
    output logic [WORD_BITS-1:0] word_rdata,
    input  logic [CNT_W-1:0]     rd_beat,
    output logic [BEAT_BITS-1:0] beat_rdata
);

    logic [BEATS*BEAT_BITS-1:0] data;

    // Contents need no reset: the owner's valid bit decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data[int'(fill_beat)*BEAT_BITS +: BEAT_BITS] <= fill_data;
        end
        if (merge_en) begin
            data[int'(merge_word)*WORD_BITS +: WORD_BITS] <=
                merge_bytes(data[int'(merge_word)*WORD_BITS +: WORD_BITS], merge_data, merge_be);
        end
    end

    assign word_rdata = data[int'(rd_word)*WORD_BITS +: WORD_BITS];
    assign beat_rdata = data[int'(rd_beat)*BEAT_BITS +: BEAT_BITS];

endmodule

// File: rtl/mem_line_bridge.sv
// Word-port to 64-bit burst memory bridge with a single write-through line buffer.
// Define MEM_LINE_BUFFER_EN to enable hit detection; otherwise every access goes to memory.
module mem_line_bridge
    import cache_types::*;
#(
    parameter int unsigned BEATS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    cpu_mem_if.slave cpu,
    pmem_if.master   pmem
);

    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned WORD_W = $clog2(BEATS * 2);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned TAG_W  = 32 - OFF_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef MEM_LINE_BUFFER_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    bridge_state_t        state;
    logic [CNT_W-1:0]     cnt;
    logic                 valid;
    logic [TAG_W-1:0]     tag;

    logic [TAG_W-1:0]     req_tag;
    logic [WORD_W-1:0]    req_word;
    logic [3:0]           req_be;
    logic [31:0]          req_wdata;
    logic                 req_write;

    logic                 mem_resp_q;
    logic [31:0]          mem_rdata_q;
    logic                 pmem_read_q;
    logic                 pmem_write_q;
    logic [63:0]          pmem_wdata_q;

    logic [TAG_W-1:0]     cpu_tag;
    logic [WORD_W-1:0]    cpu_word;
    logic                 hit;
    logic [CNT_W-1:0]     req_beat;
    logic                 req_half;
    logic [WORD_W-1:0]    rd_word;
    logic [CNT_W-1:0]     rd_beat;
    logic [31:0]          word_rdata;
    logic [63:0]          beat_rdata;
    logic [31:0]          merged_word;
    logic [31:0]          fill_word;
    logic [63:0]          flush_beat0;
    logic                 fill_en;
    logic                 merge_en;

    assign cpu_tag  = cpu.mem_address[31:OFF_W];
    assign cpu_word = cpu.mem_address[OFF_W-1:2];
    assign hit      = HIT_EN && valid && (tag == cpu_tag);
    assign req_beat = req_word[WORD_W-1:1];
    assign req_half = req_word[0];

    assign rd_word  = (state == IDLE) ? cpu_word : req_word;
    assign rd_beat  = (state == FLUSH) ? cnt + CNT_W'(1) : '0;
    assign fill_en  = (state == FILL) && pmem.pmem_resp;
    assign merge_en = (state == MERGE);

    line_buffer #(.BEATS(BEATS)) u_line (
        .clk        (clk),
        .fill_en    (fill_en),
        .fill_beat  (cnt),
        .fill_data  (pmem.pmem_rdata),
        .merge_en   (merge_en),
        .merge_word (req_word),
        .merge_data (req_wdata),
        .merge_be   (req_be),
        .rd_word    (rd_word),
        .word_rdata (word_rdata),
        .rd_beat    (rd_beat),
        .beat_rdata (beat_rdata)
    );

    assign merged_word = merge_bytes(word_rdata, req_wdata, req_be);

    // The buffer updates on the same edge the registered outputs load, so the
    // last fill beat and the merged word are forwarded around the storage.
    always_comb begin
        fill_word = word_rdata;
        if (req_beat == cnt) begin
            fill_word = req_half ? pmem.pmem_rdata[63:32] : pmem.pmem_rdata[31:0];
        end
        flush_beat0 = beat_rdata;
        if (req_beat == '0) begin
            if (req_half) flush_beat0[63:32] = merged_word;
            else          flush_beat0[31:0]  = merged_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            valid        <= 1'b0;
            tag          <= '0;
            req_tag      <= '0;
            req_word     <= '0;
            req_be       <= '0;
            req_wdata    <= '0;
            req_write    <= 1'b0;
            mem_resp_q   <= 1'b0;
            mem_rdata_q  <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_wdata_q <= '0;
        end else begin
            mem_resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu.mem_read || cpu.mem_write) begin
                        req_tag   <= cpu_tag;
                        req_word  <= cpu_word;
                        req_be    <= cpu.mem_byte_enable;
                        req_wdata <= cpu.mem_wdata;
                        req_write <= cpu.mem_write;
                        if (hit && cpu.mem_write) begin
                            state <= MERGE;
                        end else if (hit) begin
                            state       <= RESP;
                            mem_resp_q  <= 1'b1;
                            mem_rdata_q <= word_rdata;
                        end else begin
                            // The old line is overwritten beat by beat from here on.
                            state       <= FILL;
                            cnt         <= '0;
                            valid       <= 1'b0;
                            pmem_read_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (pmem.pmem_resp) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            pmem_read_q <= 1'b0;
                            valid       <= 1'b1;
                            tag         <= req_tag;
                            if (req_write) begin
                                state <= MERGE;
                            end else begin
                                state       <= RESP;
                                mem_resp_q  <= 1'b1;
                                mem_rdata_q <= fill_word;
                            end
                        end
                    end
                end
                MERGE: begin
                    state        <= FLUSH;
                    cnt          <= '0;
                    pmem_write_q <= 1'b1;
                    pmem_wdata_q <= flush_beat0;
                end
                FLUSH: begin
                    if (pmem.pmem_resp) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            state        <= RESP;
                            pmem_write_q <= 1'b0;
                            mem_resp_q   <= 1'b1;
                            mem_rdata_q  <= word_rdata;
                        end else begin
                            pmem_wdata_q <= beat_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cpu.mem_resp      = mem_resp_q;
    assign cpu.mem_rdata     = mem_rdata_q;
    assign pmem.pmem_read    = pmem_read_q;
    assign pmem.pmem_write   = pmem_write_q;
    assign pmem.pmem_address = {req_tag, {OFF_W{1'b0}}};
    assign pmem.pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_mem_line_bridge.sv
// Randomized self-checking bench for mem_line_bridge against a word-level memory model.
module tb_mem_line_bridge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_mem_if cpu ();
    pmem_if    pmem ();

    mem_line_bridge #(.BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu),
        .pmem  (pmem)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [63:0] phys  [logic [31:0]];
    logic [31:0] ref_w [logic [31:0]];

    int          gap = 0;
    logic [31:0] exp_line = '0;
    int          tx_rd_beats = 0;
    int          tx_wr_beats = 0;
    bit          model_valid = 1'b0;
    logic [31:0] model_line = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] base_beat(input logic [31:0] a);
        logic [31:0] la;
        logic [3:0]  k;
        la = {a[31:3], 3'b000};
        k  = 4'(la[4:3]) + 4'd1;
        if (la[31:5] == 27'h2) return {16{k}};
        return {la ^ 32'h5A5A_3C3C, la * 32'd2654435761};
    endfunction

    function automatic logic [63:0] phys_beat(input logic [31:0] a);
        if (phys.exists(a)) return phys[a];
        return base_beat(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [63:0] b;
        if (ref_w.exists(a)) return ref_w[a];
        b = base_beat(a);
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    // Burst memory: one beat accepted, then `gap` idle cycles, repeating.
    initial begin
        int          phase;
        int          bidx;
        logic [31:0] a;
        phase = 0;
        bidx  = 0;
        pmem.pmem_resp  = 1'b0;
        pmem.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (pmem.pmem_read || pmem.pmem_write)) begin
                if (phase == 0) begin
                    check("pmem_excl", 64'(pmem.pmem_read & pmem.pmem_write), 64'(0));
                    check("pmem_addr", 64'(pmem.pmem_address), 64'(exp_line));
                    a = pmem.pmem_address + 32'(bidx * 8);
                    if (pmem.pmem_read) begin
                        pmem.pmem_rdata = phys_beat(a);
                        tx_rd_beats++;
                    end else begin
                        phys[a] = pmem.pmem_wdata;
                        tx_wr_beats++;
                    end
                    pmem.pmem_resp = 1'b1;
                    bidx++;
                end else begin
                    pmem.pmem_resp = 1'b0;
                end
                phase = (phase >= gap) ? 0 : phase + 1;
            end else begin
                pmem.pmem_resp = 1'b0;
                phase = 0;
                bidx  = 0;
            end
        end
    end

    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input int g);
        logic [31:0] wa;
        logic [31:0] line;
        logic [31:0] exp_rdata;
        logic [31:0] got_rdata;
        bit          hit;
        bit          got_resp;
        int          bl;
        int          exp_lat;
        int          n;
        wa   = {addr[31:2], 2'b00};
        line = {addr[31:5], 5'b00000};
`ifdef MEM_LINE_BUFFER_EN
        hit = model_valid && (model_line == line);
`else
        hit = 1'b0;
`endif
        bl = 4 + 3 * g;
        if (wr) exp_lat = hit ? 2 + bl : 2 + 2 * bl;
        else    exp_lat = hit ? 1 : 1 + bl;
        if (wr) ref_w[wa] = apply_be(ref_word(wa), wd, be);
        exp_rdata = ref_word(wa);

        gap = g;
        exp_line = line;
        tx_rd_beats = 0;
        tx_wr_beats = 0;
        @(posedge clk); #1;
        cpu.mem_read        = rd;
        cpu.mem_write       = wr;
        cpu.mem_address     = addr;
        cpu.mem_byte_enable = be;
        cpu.mem_wdata       = wd;
        n = 0;
        got_resp = 1'b0;
        got_rdata = '0;
        while (n < 400 && !got_resp) begin
            @(posedge clk); #1;
            n++;
            if (cpu.mem_resp) begin
                got_resp  = 1'b1;
                got_rdata = cpu.mem_rdata;
            end
        end
        cpu.mem_read  = 1'b0;
        cpu.mem_write = 1'b0;

        check("resp_seen", 64'(got_resp), 64'(1));
        if (got_resp) begin
            check("latency", 64'(n), 64'(exp_lat));
            check("rdata", 64'(got_rdata), 64'(exp_rdata));
            check("rd_beats", 64'(tx_rd_beats), 64'(hit ? 0 : 4));
            check("wr_beats", 64'(tx_wr_beats), 64'(wr ? 4 : 0));
            if (wr) begin
                for (int k = 0; k < 4; k++) begin
                    check("flush_line", phys_beat(line + 32'(8 * k)),
                          {ref_word(line + 32'(8 * k + 4)), ref_word(line + 32'(8 * k))});
                end
            end
        end
        model_valid = 1'b1;
        model_line  = line;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          n;
        logic [31:0] a;
        int          kind;
        rst_n = 1'b0;
        cpu.mem_read = 1'b0;
        cpu.mem_write = 1'b0;
        cpu.mem_address = '0;
        cpu.mem_byte_enable = '0;
        cpu.mem_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_resp",   64'(cpu.mem_resp),      64'(0));
        check("rst_mem_rdata",  64'(cpu.mem_rdata),     64'(0));
        check("rst_pmem_read",  64'(pmem.pmem_read),    64'(0));
        check("rst_pmem_write", 64'(pmem.pmem_write),   64'(0));
        check("rst_pmem_addr",  64'(pmem.pmem_address), 64'(0));
        check("rst_pmem_wdata", pmem.pmem_wdata,        64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_txn(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 0);
        do_txn(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 0);
        do_txn(1'b0, 1'b1, 32'h0000_0048, 4'b0100, 32'hDEAD_BEEF, 0);
        do_txn(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 2);

        // Abort a flush of line 0x80 partway; the target word sits in the last beat.
        gap = 0;
        exp_line = 32'h80;
        tx_rd_beats = 0;
        tx_wr_beats = 0;
        @(posedge clk); #1;
        cpu.mem_write = 1'b1;
        cpu.mem_address = 32'h0000_009C;
        cpu.mem_byte_enable = 4'hF;
        cpu.mem_wdata = 32'hCAFE_F00D;
        n = 0;
        while (n < 200 && tx_wr_beats < 2) begin
            @(negedge clk);
            n++;
        end
        check("flush_reached", 64'(tx_wr_beats >= 2), 64'(1));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_pmem_write", 64'(pmem.pmem_write), 64'(0));
        check("abort_pmem_read",  64'(pmem.pmem_read),  64'(0));
        check("abort_mem_resp",   64'(cpu.mem_resp),    64'(0));
        cpu.mem_write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_valid = 1'b0;
        do_txn(1'b1, 1'b0, 32'h0000_009C, 4'h0, 32'h0, 0);

        do_txn(1'b1, 1'b1, 32'h0000_0060, 4'b1001, 32'h1234_5678, 0);

        for (int i = 0; i < 60; i++) begin
            a = 32'h200 + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2)
                + 32'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            do_txn(kind != 2, kind >= 2, a, 4'($urandom), $urandom, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
